// File: rtl/avalon_mm_mem_tester.sv
// Avalon-MM memory tester: writes a generated pattern over a word range of a
// fixed-latency RAM slave, reads the range back and compares it against the
// regenerated pattern, reporting pass/fail, error count and first bad address.
// Optional feature: define MEM_TESTER_LFSR_EN to use a 32-bit Galois LFSR
// pattern instead of the default seed+index ramp.
module avalon_mm_mem_tester #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FIN} state_e;

  localparam logic [ADDR_W:0] IDX_ONE = 1;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [31:0]         seed_q, seed_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic                first_seen_q, first_seen_d;

  // Read-compare pipe: one slot per cycle of read latency.
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [ADDR_W-1:0]       pipe_addr_q [READ_LATENCY];
  logic [31:0]             pipe_exp_q  [READ_LATENCY];

  logic [31:0]       pattern;
  logic [ADDR_W-1:0] cur_addr;
  logic              start_ok, wr_acc, rd_acc, last, mismatch, pipe_empty;

  assign start_ok   = (state_q == S_IDLE) && start;
  assign cur_addr   = base_q + idx_q[ADDR_W-1:0];
  assign wr_acc     = (state_q == S_WRITE) && !avm_waitrequest;
  assign rd_acc     = (state_q == S_READ) && !avm_waitrequest;
  assign last       = (idx_q + IDX_ONE) == num_q;
  assign mismatch   = pipe_vld_q[READ_LATENCY-1] &&
                      (avm_readdata != pipe_exp_q[READ_LATENCY-1]);
  assign pipe_empty = ~|pipe_vld_q;

`ifdef MEM_TESTER_LFSR_EN
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  logic [31:0] lfsr_q, lfsr_d;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  // LFSR advances once per accepted transfer and restarts from the seed for the read pass.
  always_comb begin
    lfsr_d = lfsr_q;
    if (start_ok)                lfsr_d = lfsr_seed(seed);
    else if (wr_acc && last)     lfsr_d = lfsr_seed(seed_q);
    else if (wr_acc || rd_acc)   lfsr_d = lfsr_step(lfsr_q);
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 32'd1;
    else          lfsr_q <= lfsr_d;
  end

  assign pattern = lfsr_q;
`else
  assign pattern = seed_q + 32'(idx_q);
`endif

  // Next-state and datapath update for the test sequencer.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    idx_d        = idx_q;
    num_d        = num_q;
    base_d       = base_q;
    seed_d       = seed_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    first_d      = first_q;
    first_seen_d = first_seen_q;

    if (mismatch) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (!first_seen_q) begin
        first_d      = pipe_addr_q[READ_LATENCY-1];
        first_seen_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d       = base_addr;
          num_d        = num_words;
          seed_d       = seed;
          idx_d        = '0;
          err_d        = '0;
          first_d      = '0;
          first_seen_d = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = (num_words == '0) ? S_FIN : S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          if (last) begin
            idx_d   = '0;
            state_d = S_READ;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      S_READ: begin
        if (rd_acc) begin
          if (last) state_d = S_DRAIN;
          else      idx_d   = idx_q + IDX_ONE;
        end
      end
      S_DRAIN: begin
        if (pipe_empty) state_d = S_FIN;
      end
      S_FIN: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 16'd0);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Control, result and pipe-valid registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q        <= '0;
      num_q        <= '0;
      base_q       <= '0;
      seed_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      first_q      <= '0;
      first_seen_q <= 1'b0;
      pipe_vld_q   <= '0;
    end else begin
      idx_q        <= idx_d;
      num_q        <= num_d;
      base_q       <= base_d;
      seed_q       <= seed_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      first_q      <= first_d;
      first_seen_q <= first_seen_d;
      pipe_vld_q[0] <= rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  // Pipe payload shifts every cycle; only slots flagged valid are ever compared.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; the reset valid bits make stale contents harmless.
    pipe_addr_q[0] <= cur_addr;
    pipe_exp_q[0]  <= pattern;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_addr_q[i] <= pipe_addr_q[i-1];
      pipe_exp_q[i]  <= pipe_exp_q[i-1];
    end
  end

  assign avm_write      = (state_q == S_WRITE);
  assign avm_read       = (state_q == S_READ);
  assign avm_chipselect = avm_write || avm_read;
  assign avm_byteenable = 4'hF;
  assign avm_address    = avm_chipselect ? cur_addr : '0;
  assign avm_writedata  = avm_write ? pattern : 32'd0;

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_avalon_mm_mem_tester.sv
// Self-checking bench for avalon_mm_mem_tester: a behavioural RAM slave with
// fixed read latency, optional random waitrequest and a one-address read
// corruption, checked against a pattern/address model computed from the
// tester's rules (default ramp pattern build).
module tb_avalon_mm_mem_tester;

  localparam int AW    = 10;
  localparam int RL    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic [31:0]   seed = '0;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [AW-1:0] avm_address;
  logic [3:0]    avm_byteenable;
  logic          avm_chipselect, avm_write, avm_read;
  logic [31:0]   avm_writedata;
  logic [31:0]   avm_readdata = '0;
  logic          avm_waitrequest = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_mm_mem_tester #(.ADDR_W(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  // Slave model state.
  typedef struct { int due; logic [31:0] data; } rd_t;
  logic [31:0]   mem [DEPTH];
  int            wr_count = 0, rd_count = 0, cyc = 0;
  logic [AW-1:0] wr_log[$], rd_log[$];
  rd_t           rd_pipe[$];
  bit            stall_en = 0, corrupt_en = 0;
  logic [AW-1:0] corrupt_addr = '0;

  // RAM slave: transfer accepted at an edge when request is high and waitrequest low.
  initial begin : slave
    bit aw, ar;
    logic [AW-1:0] a;
    logic [31:0] d;
    rd_t e;
    forever begin
      @(negedge clk);
      aw = avm_write && !avm_waitrequest;
      ar = avm_read && !avm_waitrequest;
      a  = avm_address;
      d  = avm_writedata;
      @(posedge clk);
      cyc++;
      if (aw) begin mem[a] = d; wr_count++; wr_log.push_back(a); end
      if (ar) begin
        e.due  = cyc + RL - 1;
        e.data = mem[a] ^ ((corrupt_en && a == corrupt_addr) ? 32'h0000_0100 : 32'h0);
        rd_pipe.push_back(e);
        rd_count++;
        rd_log.push_back(a);
      end
      #1;
      if (rd_pipe.size() > 0 && rd_pipe[0].due == cyc) begin
        avm_readdata = rd_pipe[0].data;
        void'(rd_pipe.pop_front());
      end else begin
        avm_readdata = $urandom;
      end
      avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic run_test(input string name, input logic [AW-1:0] b, input logic [AW:0] n,
                          input logic [31:0] s, input bit stall, input bit corr,
                          input logic [AW-1:0] caddr, input bit restart);
    int exp_err, lat, bad_wr, bad_rd, bad_mem, nn;
    logic [AW-1:0] exp_first, ea;
    bit seen, got;
    nn = int'(n);
    exp_err = 0; exp_first = '0; seen = 0;
    for (int i = 0; i < nn; i++) begin
      ea = AW'((int'(b) + i) % DEPTH);
      if (corr && ea == caddr) begin
        exp_err++;
        if (!seen) begin exp_first = ea; seen = 1; end
      end
    end
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    wr_count = 0; rd_count = 0; wr_log.delete(); rd_log.delete();
    stall_en = stall; corrupt_en = corr; corrupt_addr = caddr;

    @(negedge clk);
    base_addr = b; num_words = n; seed = s; start = 1'b1;
    got = 0; lat = 0;
    for (int k = 1; k <= 20000 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %b want 1", name, busy); end
      end
      if (restart && k == 3) begin
        start = 1'b1; base_addr = ~b; num_words = n + 1; seed = ~s;
      end
      if (restart && k == 4) start = 1'b0;
      if (done === 1'b1) begin got = 1; lat = k; end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s done_timeout got none want done pulse", name);
    end else begin
      checks++;
      if (nn == 0 ? (lat != 2) : (lat < 2 * nn + RL + 2)) begin
        errors++; $display("FAIL %s latency got %0d cycles for %0d words", name, lat, nn);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", name, busy); end
      checks++;
      if (err_count !== 16'(exp_err)) begin
        errors++; $display("FAIL %s err_count got %0d want %0d", name, err_count, exp_err);
      end
      checks++;
      if (first_err_addr !== exp_first) begin
        errors++; $display("FAIL %s first_err_addr got %h want %h", name, first_err_addr, exp_first);
      end
      checks++;
      if (pass !== (exp_err == 0)) begin
        errors++; $display("FAIL %s pass got %b want %b", name, pass, exp_err == 0);
      end
    end
    checks++;
    if (wr_count != nn || rd_count != nn) begin
      errors++; $display("FAIL %s transfers got wr %0d rd %0d want %0d each", name, wr_count, rd_count, nn);
    end
    bad_wr = 0; bad_rd = 0; bad_mem = 0;
    for (int i = 0; i < nn; i++) begin
      ea = AW'((int'(b) + i) % DEPTH);
      if (i >= wr_log.size() || wr_log[i] !== ea) bad_wr++;
      if (i >= rd_log.size() || rd_log[i] !== ea) bad_rd++;
      if (mem[ea] !== s + 32'(i)) bad_mem++;
    end
    checks++;
    if (bad_wr != 0 || bad_rd != 0) begin
      errors++; $display("FAIL %s address_order got %0d wr %0d rd bad want 0", name, bad_wr, bad_rd);
    end
    checks++;
    if (bad_mem != 0) begin
      errors++; $display("FAIL %s write_data got %0d bad words want 0", name, bad_mem);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || pass !== (exp_err == 0)) begin
      errors++; $display("FAIL %s after_done got done %b pass %b want 0 %b", name, done, pass, exp_err == 0);
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, err_count, first_err_addr, avm_address, avm_chipselect,
         avm_write, avm_read, avm_writedata} !== '0 || avm_byteenable !== 4'hF) begin
      errors++;
      $display("FAIL reset_outputs got busy %b done %b pass %b err %h addr %h wr %b rd %b be %h",
               busy, done, pass, err_count, avm_address, avm_write, avm_read, avm_byteenable);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    run_test("basic", '0, 11'd16, 32'h100, 0, 0, '0, 0);
  endtask

  task automatic test_corrupt();
    run_test("corrupt", '0, 11'd16, 32'h100, 0, 1, 10'd5, 0);
  endtask

  task automatic test_stall();
    run_test("stall", AW'($urandom), 11'd64, $urandom, 1, 0, '0, 0);
  endtask

  task automatic test_wrap();
    run_test("wrap", 10'h3FE, 11'd4, 32'hFFFF_FFFE, 1, 1, 10'h000, 0);
  endtask

  task automatic test_zero();
    run_test("zero", 10'h123, 11'd0, 32'h55, 0, 0, '0, 0);
    checks++;
    if (wr_count != 0 || rd_count != 0) begin
      errors++; $display("FAIL zero_no_transfers got wr %0d rd %0d want 0", wr_count, rd_count);
    end
  endtask

  task automatic test_start_while_busy();
    run_test("restart", 10'h200, 11'd20, 32'hABCD_0000, 1, 0, '0, 1);
  endtask

  task automatic test_full_range();
    run_test("full", AW'($urandom), 11'd1024, 32'hFFFF_FFF0, 0, 1, AW'($urandom), 0);
  endtask

  task automatic test_random();
    logic [AW-1:0] b, c;
    logic [AW:0] n;
    for (int it = 0; it < 6; it++) begin
      b = AW'($urandom);
      n = (AW+1)'($urandom_range(1, 100));
      c = AW'(int'(b) + int'($urandom_range(0, int'(n) + 5)));
      run_test("random", b, n, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c, 0);
    end
  endtask

  task automatic test_reset_mid_write();
    bit saw_done;
    stall_en = 0; corrupt_en = 0;
    @(negedge clk);
    base_addr = 10'h010; num_words = 11'd64; seed = 32'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (avm_write !== 1'b0 || avm_chipselect !== 1'b0 || busy !== 1'b0 || err_count !== '0) begin
      errors++;
      $display("FAIL reset_mid_write got wr %b cs %b busy %b err %h want 0", avm_write, avm_chipselect, busy, err_count);
    end
    saw_done = 0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) saw_done = 1; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) saw_done = 1; end
    checks++;
    if (saw_done) begin errors++; $display("FAIL reset_no_done got done pulse want none"); end
    rd_pipe.delete();
    run_test("after_reset", 10'h3F0, 11'd32, 32'h7777_0000, 1, 0, '0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corrupt();
    test_stall();
    test_wrap();
    test_zero();
    test_start_while_busy();
    test_full_range();
    test_random();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
